// File: rtl/l1_mem_pkg.sv
// l1_mem_pkg: opcodes, line geometry and FSM state type for l1_mem_responder. Rev 1.0
`default_nettype none

package l1_mem_pkg;

    localparam logic [4:0] OP_LD_LINE = 5'd4;
    localparam logic [4:0] OP_ST_LINE = 5'd7;
    localparam int         LINE_BYTES = 16;
    localparam int         LINE_BITS  = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic is_known_op(input logic [4:0] op);
        return (op == OP_LD_LINE) || (op == OP_ST_LINE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/l1_mem_line_ram.sv
// l1_mem_line_ram: single-port LINES x LINE_BITS synchronous RAM, no reset. Rev 1.0
`default_nettype none

module l1_mem_line_ram
    import l1_mem_pkg::*;
#(
    parameter int LINES  = 1024,
    parameter int IDX_W  = 10
) (
    input  logic                 clk,
    input  logic                 re_i,
    input  logic                 we_i,
    input  logic [IDX_W-1:0]     addr_i,
    input  logic [LINE_BITS-1:0] wdata_i,
    output logic [LINE_BITS-1:0] rdata_o
);

    logic [LINE_BITS-1:0] mem_q [LINES];
    logic [LINE_BITS-1:0] rdata_q;

    // Read data only changes on a read, so it holds across writes and idle cycles.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/l1_mem_responder.sv
// l1_mem_responder: fixed-latency line memory responder for the L1 refill/writeback port. Rev 1.0
// Optional build macro L1_MEM_RESPONDER_JITTER_EN adds 0..7 cycles of LFSR latency jitter.
`default_nettype none

module l1_mem_responder
    import l1_mem_pkg::*;
#(
    parameter int LINES   = 1024,
    parameter int LATENCY = 4,
    parameter int CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_req_valid_i,
    input  logic [63:0]          mem_req_addr_i,
    input  logic [LINE_BITS-1:0] mem_req_store_data_i,
    input  logic [1:0]           mem_req_tag_i,
    input  logic                 mem_req_insn_i,
    input  logic [4:0]           mem_req_opcode_i,
    output logic                 mem_req_ack_o,
    output logic                 mem_rsp_valid_o,
    output logic [LINE_BITS-1:0] mem_rsp_load_data_o,
    output logic [1:0]           mem_rsp_tag_o,
    output logic [4:0]           mem_rsp_opcode_o,
    output logic                 busy_o,
    output logic [CNT_W-1:0]     iside_reqs_o,
    output logic [CNT_W-1:0]     dside_reqs_o,
    output logic                 bad_op_o
);

    localparam int IDX_W = $clog2(LINES);
    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int LAT_W = $clog2(LATENCY + 8);

    state_e               state_q;
    logic [LAT_W-1:0]     cnt_q;
    logic [IDX_W-1:0]     idx_q;
    logic [LINE_BITS-1:0] data_q;
    logic [1:0]           tag_q;
    logic [4:0]           op_q;
    logic                 ack_q;
    logic                 rsp_valid_q;
    logic [1:0]           rsp_tag_q;
    logic [4:0]           rsp_op_q;
    logic                 rsp_ld_q;
    logic [CNT_W-1:0]     iside_q;
    logic [CNT_W-1:0]     dside_q;
    logic                 bad_op_q;
    logic [LAT_W-1:0]     jitter;
    logic [LINE_BITS-1:0] ram_rdata;
    logic                 unused_addr_bits;

    assign unused_addr_bits = ^{mem_req_addr_i[63:OFF_W+IDX_W], mem_req_addr_i[OFF_W-1:0]};

`ifdef L1_MEM_RESPONDER_JITTER_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign jitter = LAT_W'(lfsr_q[2:0]);
`else
    assign jitter = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            data_q      <= '0;
            tag_q       <= '0;
            op_q        <= '0;
            ack_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_tag_q   <= '0;
            rsp_op_q    <= '0;
            rsp_ld_q    <= 1'b0;
            iside_q     <= '0;
            dside_q     <= '0;
            bad_op_q    <= 1'b0;
        end else begin
            ack_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_req_valid_i) begin
                        idx_q   <= mem_req_addr_i[OFF_W +: IDX_W];
                        data_q  <= mem_req_store_data_i;
                        tag_q   <= mem_req_tag_i;
                        op_q    <= mem_req_opcode_i;
                        ack_q   <= 1'b1;
                        cnt_q   <= LAT_W'(LATENCY - 1) + jitter;
                        state_q <= WAIT;
                        if (mem_req_insn_i) begin
                            if (iside_q != '1) iside_q <= iside_q + 1'b1;
                        end else begin
                            if (dside_q != '1) dside_q <= dside_q + 1'b1;
                        end
                        if (!is_known_op(mem_req_opcode_i)) begin
                            bad_op_q <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_tag_q   <= tag_q;
                        rsp_op_q    <= op_q;
                        rsp_ld_q    <= (op_q == OP_LD_LINE);
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The RAM output register is the load-data register; rsp_ld_q masks it for non-loads and reset.
    l1_mem_line_ram #(
        .LINES (LINES),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk     (clk),
        .re_i    ((state_q == WAIT) && (cnt_q == '0) && (op_q == OP_LD_LINE)),
        .we_i    ((state_q == RESP) && (op_q == OP_ST_LINE)),
        .addr_i  (idx_q),
        .wdata_i (data_q),
        .rdata_o (ram_rdata)
    );

    assign mem_req_ack_o       = ack_q;
    assign mem_rsp_valid_o     = rsp_valid_q;
    assign mem_rsp_load_data_o = rsp_ld_q ? ram_rdata : '0;
    assign mem_rsp_tag_o       = rsp_tag_q;
    assign mem_rsp_opcode_o    = rsp_op_q;
    assign busy_o              = (state_q != IDLE);
    assign iside_reqs_o        = iside_q;
    assign dside_reqs_o        = dside_q;
    assign bad_op_o            = bad_op_q;

endmodule

`default_nettype wire

// File: tb/tb_l1_mem_responder.sv
// tb_l1_mem_responder: directed table, corner sequences and randomized requests against a line-memory model. Rev 1.0
`default_nettype none

module tb_l1_mem_responder;
    import l1_mem_pkg::*;

    localparam int LINES   = 1024;
    localparam int LATENCY = 4;
    localparam int CNT_W   = 32;
`ifdef L1_MEM_RESPONDER_JITTER_EN
    localparam int LAT_MAX = LATENCY + 7;
`else
    localparam int LAT_MAX = LATENCY;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         mem_req_valid_i = 1'b0;
    logic [63:0]  mem_req_addr_i = '0;
    logic [127:0] mem_req_store_data_i = '0;
    logic [1:0]   mem_req_tag_i = '0;
    logic         mem_req_insn_i = 1'b0;
    logic [4:0]   mem_req_opcode_i = '0;
    logic         mem_req_ack_o;
    logic         mem_rsp_valid_o;
    logic [127:0] mem_rsp_load_data_o;
    logic [1:0]   mem_rsp_tag_o;
    logic [4:0]   mem_rsp_opcode_o;
    logic         busy_o;
    logic [CNT_W-1:0] iside_reqs_o;
    logic [CNT_W-1:0] dside_reqs_o;
    logic         bad_op_o;

    l1_mem_responder #(.LINES(LINES), .LATENCY(LATENCY), .CNT_W(CNT_W)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .mem_req_valid_i      (mem_req_valid_i),
        .mem_req_addr_i       (mem_req_addr_i),
        .mem_req_store_data_i (mem_req_store_data_i),
        .mem_req_tag_i        (mem_req_tag_i),
        .mem_req_insn_i       (mem_req_insn_i),
        .mem_req_opcode_i     (mem_req_opcode_i),
        .mem_req_ack_o        (mem_req_ack_o),
        .mem_rsp_valid_o      (mem_rsp_valid_o),
        .mem_rsp_load_data_o  (mem_rsp_load_data_o),
        .mem_rsp_tag_o        (mem_rsp_tag_o),
        .mem_rsp_opcode_o     (mem_rsp_opcode_o),
        .busy_o               (busy_o),
        .iside_reqs_o         (iside_reqs_o),
        .dside_reqs_o         (dside_reqs_o),
        .bad_op_o             (bad_op_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Behavioural model: a plain line array plus request tallies.
    logic [127:0] mdl_mem [LINES];
    int           wq[$];
    logic [31:0]  mdl_i = 0;
    logic [31:0]  mdl_d = 0;
    logic         mdl_bad = 0;

    typedef struct {
        logic [63:0]  addr;
        logic [127:0] data;
        logic [1:0]   tag;
        logic         insn;
        logic [4:0]   op;
        logic [127:0] exp_data;
        logic         exp_bad;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_ack"},   mem_req_ack_o, 0);
        chk({name, "_rspv"},  mem_rsp_valid_o, 0);
        chk({name, "_data"},  mem_rsp_load_data_o, 0);
        chk({name, "_tagop"}, {mem_rsp_tag_o, mem_rsp_opcode_o}, 0);
        chk({name, "_busy"},  busy_o, 0);
        chk({name, "_cnt"},   {iside_reqs_o, dside_reqs_o}, 0);
        chk({name, "_bad"},   bad_op_o, 0);
    endtask

    // Drives one request from a negedge and returns at the negedge of its response cycle.
    task automatic run_req(input logic [63:0] a, input logic [127:0] d, input logic [1:0] t,
                           input logic ins, input logic [4:0] op, input bit flush,
                           output logic [127:0] rd, output logic [1:0] rt, output logic [4:0] ro,
                           output int lat, output int ack_wait, output int ack_cyc);
        int n;
        rd = '0; rt = '0; ro = '0; lat = 0; ack_cyc = 0;
        mem_req_valid_i = 1'b1;
        mem_req_addr_i = a; mem_req_store_data_i = d; mem_req_tag_i = t;
        mem_req_insn_i = ins; mem_req_opcode_i = op;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            chk("rsp_single_cycle", mem_rsp_valid_o, 0);
        end while (!mem_req_ack_o && n < 16);
        ack_wait = n;
        chk("ack_seen", mem_req_ack_o, 1);
        if (!mem_req_ack_o) begin
            mem_req_valid_i = 1'b0;
            return;
        end
        ack_cyc = cyc;
        chk("busy_wait", busy_o, 1);
        mem_req_addr_i = {$urandom, $urandom};
        mem_req_store_data_i = {$urandom, $urandom, $urandom, $urandom};
        mem_req_tag_i = 2'($urandom); mem_req_opcode_i = 5'($urandom); mem_req_insn_i = 1'($urandom);
        while (!mem_rsp_valid_o && lat < 16) begin
            if (flush) mem_req_valid_i = 1'b0;
            @(negedge clk);
            lat++;
            chk("no_reack", mem_req_ack_o, 0);
        end
        chk("rsp_seen", mem_rsp_valid_o, 1);
        rd = mem_rsp_load_data_o; rt = mem_rsp_tag_o; ro = mem_rsp_opcode_o;
        mem_req_valid_i = 1'b0;
    endtask

    task automatic issue(input logic [63:0] a, input logic [127:0] d, input logic [1:0] t,
                         input logic ins, input logic [4:0] op, input bit flush,
                         output logic [127:0] rd, output int lat, output int ack_wait, output int ack_cyc);
        logic [127:0] exp_d;
        logic [1:0]   rt;
        logic [4:0]   ro;
        int           idx;
        idx = int'(a[13:4]) % LINES;
        exp_d = (op == OP_LD_LINE) ? mdl_mem[idx] : '0;
        run_req(a, d, t, ins, op, flush, rd, rt, ro, lat, ack_wait, ack_cyc);
        if (ins) begin if (mdl_i != '1) mdl_i++; end
        else     begin if (mdl_d != '1) mdl_d++; end
        if (op != OP_LD_LINE && op != OP_ST_LINE) mdl_bad = 1'b1;
        if (op == OP_ST_LINE) begin mdl_mem[idx] = d; wq.push_back(idx); end
        chk("rsp_data", rd, exp_d);
        chk("rsp_tag", rt, t);
        chk("rsp_opcode", ro, op);
        chk("latency_in_range", (lat >= LATENCY && lat <= LAT_MAX), 1);
        chk("bad_op", bad_op_o, mdl_bad);
        chk("iside_reqs", iside_reqs_o, mdl_i);
        chk("dside_reqs", dside_reqs_o, mdl_d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_req_valid_i = 1'b0;
        mdl_i = 0; mdl_d = 0; mdl_bad = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    localparam logic [127:0] D1 = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    localparam logic [127:0] D2 = 128'hA5A5_0F0F_1234_5678_9ABC_DEF0_CAFE_F00D;

    initial begin
        logic [127:0] rd;
        int lat, aw, ac, prev_ac, prev_lat;
        logic [127:0] d3;
        bit flag;

        vecs[0] = '{64'h100,  D1, 2'd2, 1'b0, OP_ST_LINE, '0, 1'b0};
        vecs[1] = '{64'h10F,  '0, 2'd1, 1'b1, OP_LD_LINE, D1, 1'b0};
        vecs[2] = '{64'h200,  D2, 2'd3, 1'b0, 5'd3,       '0, 1'b1};
        vecs[3] = '{64'h100,  '0, 2'd0, 1'b1, OP_LD_LINE, D1, 1'b1};
        vecs[4] = '{64'h4100, D2, 2'd1, 1'b0, OP_ST_LINE, '0, 1'b1};
        vecs[5] = '{64'h0100, '0, 2'd2, 1'b1, OP_LD_LINE, D2, 1'b1};

        #1;
        chk_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back alternating d-store / i-load; one idle cycle separates RESP and the next accept.
        prev_ac = 0; prev_lat = 0;
        for (int k = 0; k < 20; k++) begin
            logic [63:0]  a;
            a = 64'(32'h1000 + (k / 2) * 16);
            issue(a, {4{$urandom}}, 2'(k), (k % 2) == 1, (k % 2) == 1 ? OP_LD_LINE : OP_ST_LINE,
                  1'b0, rd, lat, aw, ac);
            chk("b2b_ack_wait", aw, (k == 0) ? 1 : 2);
            if (k > 0) chk("b2b_spacing", ac - prev_ac, prev_lat + 2);
            prev_ac = ac; prev_lat = lat;
        end
        chk("b2b_iside", iside_reqs_o, 10);
        chk("b2b_dside", dside_reqs_o, 10);

        do_reset();
        chk_reset_outputs("reset2");

        foreach (vecs[i]) begin
            @(negedge clk);
            issue(vecs[i].addr, vecs[i].data, vecs[i].tag, vecs[i].insn, vecs[i].op, 1'b0, rd, lat, aw, ac);
            chk("vec_ack_next_cycle", aw, 1);
            chk("vec_data", rd, vecs[i].exp_data);
            chk("vec_bad_op", bad_op_o, vecs[i].exp_bad);
`ifndef L1_MEM_RESPONDER_JITTER_EN
            chk("vec_latency", lat, LATENCY);
`endif
            @(negedge clk);
            chk("vec_rsp_one_cycle", mem_rsp_valid_o, 0);
            chk("vec_tag_hold", mem_rsp_tag_o, vecs[i].tag);
        end

        // Initiator flush: valid drops during WAIT, response still comes.
        @(negedge clk);
        issue(64'h100, '0, 2'd3, 1'b0, OP_LD_LINE, 1'b1, rd, lat, aw, ac);

        // Reset in WAIT drops the request; the backing store survives.
        d3 = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        issue(64'h300, d3, 2'd1, 1'b0, OP_ST_LINE, 1'b0, rd, lat, aw, ac);
        @(negedge clk);
        mem_req_valid_i = 1'b1; mem_req_addr_i = 64'h300; mem_req_opcode_i = OP_LD_LINE; mem_req_tag_i = 2'd2;
        @(negedge clk);
        chk("rst_pre_ack", mem_req_ack_o, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        mdl_i = 0; mdl_d = 0; mdl_bad = 0;
        @(negedge clk);
        mem_req_valid_i = 1'b0;
        rst_n = 1'b1;
        flag = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (mem_rsp_valid_o) flag = 1'b1;
        end
        chk("rst_no_rsp", flag, 0);
        issue(64'h300, '0, 2'd0, 1'b1, OP_LD_LINE, 1'b0, rd, lat, aw, ac);
        chk("rst_store_kept", rd, d3);

        // Random mixed traffic with aliasing upper address bits.
        for (int k = 0; k < 200; k++) begin
            logic [63:0] a;
            logic [4:0]  op;
            int          r;
            a = {$urandom, $urandom};
            r = $urandom_range(0, 9);
            if (r < 5) begin
                op = OP_ST_LINE;
                a[13:4] = 10'($urandom_range(0, 31));
            end else if (r < 9) begin
                op = OP_LD_LINE;
                a[13:4] = 10'(wq[$urandom_range(0, wq.size() - 1)]);
            end else begin
                op = 5'($urandom_range(8, 31));
            end
            @(negedge clk);
            issue(a, {$urandom, $urandom, $urandom, $urandom}, 2'($urandom), 1'($urandom), op,
                  1'($urandom_range(0, 3) == 0), rd, lat, aw, ac);
        end

`ifdef L1_MEM_RESPONDER_JITTER_EN
        begin
            bit seen[16];
            int nvals;
            nvals = 0;
            for (int k = 0; k < 1000; k++) begin
                logic [63:0] a;
                a = {$urandom, $urandom};
                a[13:4] = 10'(wq[$urandom_range(0, wq.size() - 1)]);
                issue(a, '0, 2'($urandom), 1'($urandom), OP_LD_LINE, 1'b0, rd, lat, aw, ac);
                if (lat < 16 && !seen[lat]) begin seen[lat] = 1'b1; nvals++; end
            end
            chk("jitter_variety", nvals > 1, 1);
        end
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
